// File: rtl/trace_pkg.sv
// trace_pkg: shared constants and types for the trace snapshot packer.
//   TRACE_W / THREADS       : trace word width and thread count
//   *_LSB / *_W             : bit position and width of each field in a trace word
//   trace_word_t            : one packed thread trace word
//   trace_words_t           : all thread words, thread 0 in the least significant slot
//   snapshot_t              : thread words plus a default-width timestamp
//   pack_trace()            : assembles one trace word from per-thread fields
package trace_pkg;

  localparam int TRACE_W     = 36;
  localparam int THREADS     = 4;
  localparam int DEF_TS_BITS = 16;

  localparam int ACT_LSB  = 0;
  localparam int ACT_W    = 1;
  localparam int PC_LSB   = 1;
  localparam int PC_W     = 8;
  localparam int MREQ_LSB = 9;
  localparam int MREQ_W   = 1;
  localparam int ADDR_LSB = 10;
  localparam int ADDR_W   = 8;
  localparam int DATA_LSB = 18;
  localparam int DATA_W   = 8;
  localparam int LSU_LSB  = 26;
  localparam int LSU_W    = 2;
  localparam int RES_LSB  = 28;
  localparam int RES_W    = 8;

  typedef logic [TRACE_W-1:0] trace_word_t;
  typedef trace_word_t [THREADS-1:0] trace_words_t;

  typedef struct packed {
    trace_words_t           words;
    logic [DEF_TS_BITS-1:0] ts;
  } snapshot_t;

  function automatic trace_word_t pack_trace(
    input logic              act,
    input logic [PC_W-1:0]   pc,
    input logic              mreq,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data,
    input logic [LSU_W-1:0]  lsu,
    input logic [RES_W-1:0]  res
  );
    trace_word_t w;
    w                      = '0;
    w[ACT_LSB]             = act;
    w[PC_LSB   +: PC_W]    = pc;
    w[MREQ_LSB]            = mreq;
    w[ADDR_LSB +: ADDR_W]  = addr;
    w[DATA_LSB +: DATA_W]  = data;
    w[LSU_LSB  +: LSU_W]   = lsu;
    w[RES_LSB  +: RES_W]   = res;
    return w;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: parameterized show-ahead synchronous FIFO.
//   clk, reset_n : clock, asynchronous active-low reset (storage zeroed)
//   clear        : synchronous flush of pointers and level
//   push, wdata  : write request; accepted when not full or when popping the same cycle
//   pop          : read request; ignored when empty
//   rdata        : head entry, read straight out of the storage registers
//   full, empty  : occupancy flags
//   level        : number of stored entries
module trace_fifo #(
  parameter int WIDTH = 160,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty     = (r_level == '0);
  assign full      = (r_level == LW'(DEPTH));
  assign level     = r_level;
  assign rdata     = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  // When full, the write slot is the head being popped this cycle.
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= wdata;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_level <= r_level + LW'(w_do_push) - LW'(w_do_pop);
    end
  end

endmodule

// File: rtl/trace_snapshot_packer.sv
// trace_snapshot_packer: samples per-thread debug signals, packs each thread into
// a 36-bit trace word and queues timestamped 4-word snapshots for a valid/ready consumer.
//   clk, reset_n              : clock, asynchronous active-low reset
//   enable                    : capture enable
//   mode                      : 0 = capture every enabled cycle, 1 = capture on change only
//   clear                     : synchronous flush of FIFO, drop counter and primed flag
//   t_active..t_result        : per-thread debug inputs, thread i in slice i
//   out_valid, out_ready      : head snapshot handshake
//   word0..word3, out_ts      : head snapshot trace words and timestamp
//   fifo_level                : FIFO occupancy
//   drop_count                : snapshots lost to overflow, saturating
module trace_snapshot_packer
  import trace_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int TS_BITS   = 16,
  parameter int DROP_BITS = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     mode,
  input  logic                     clear,
  input  logic [3:0]               t_active,
  input  logic [31:0]              t_pc,
  input  logic [3:0]               t_mem_req,
  input  logic [31:0]              t_addr,
  input  logic [31:0]              t_data,
  input  logic [7:0]               t_lsu,
  input  logic [31:0]              t_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [35:0]              word0,
  output logic [35:0]              word1,
  output logic [35:0]              word2,
  output logic [35:0]              word3,
  output logic [TS_BITS-1:0]       out_ts,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [DROP_BITS-1:0]     drop_count
);

  localparam int SNAP_W = TRACE_W * THREADS + TS_BITS;

  trace_words_t           w_packed;
  logic [SNAP_W-1:0]      w_head;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_attempt;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;

  logic [TS_BITS-1:0]     r_ts;
  logic                   r_primed;
  trace_words_t           r_last;
  logic [DROP_BITS-1:0]   r_drop;

  always_comb begin
    w_packed = '0;
    for (int unsigned i = 0; i < THREADS; i++) begin
      w_packed[i] = pack_trace(t_active[i], t_pc[8*i +: 8], t_mem_req[i],
                               t_addr[8*i +: 8], t_data[8*i +: 8],
                               t_lsu[2*i +: 2], t_result[8*i +: 8]);
    end
  end

  // An unprimed capturer always fires once so change-only mode has a reference.
  assign w_attempt = enable && !clear && (!mode || !r_primed || (w_packed != r_last));
  assign w_pop     = !w_empty && out_ready;
  assign w_push    = w_attempt && (!w_full || w_pop);
  assign w_drop    = w_attempt && w_full && !w_pop;

  trace_fifo #(
    .WIDTH (SNAP_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .push    (w_push),
    .pop     (w_pop),
    .wdata   ({w_packed, r_ts}),
    .rdata   (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .level   (fifo_level)
  );

  assign {word3, word2, word1, word0, out_ts} = w_head;
  assign out_valid  = !w_empty;
  assign drop_count = r_drop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ts     <= '0;
      r_primed <= 1'b0;
      r_last   <= '0;
      r_drop   <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;

      if (!enable || clear) begin
        r_primed <= 1'b0;
      end else if (w_attempt) begin
        r_primed <= 1'b1;
      end

      if (w_attempt) begin
        r_last <= w_packed;
      end

      if (clear) begin
        r_drop <= '0;
      end else if (w_drop && (r_drop != '1)) begin
        r_drop <= r_drop + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_trace_snapshot_packer.sv
// tb_trace_snapshot_packer: directed scenarios followed by randomized traffic,
// all checked against a queue-based reference model of the snapshot packer.
module tb_trace_snapshot_packer;

  localparam int DEPTH     = 4;
  localparam int TS_BITS   = 16;
  localparam int DROP_BITS = 8;
  localparam int LVL_W     = $clog2(DEPTH) + 1;
  localparam int SNAP_W    = 144 + TS_BITS;
  localparam int DROP_MAX  = (1 << DROP_BITS) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic mode = 1'b0;
  logic clear = 1'b0;
  logic out_ready = 1'b0;
  logic [3:0]  t_active = '0;
  logic [31:0] t_pc = '0;
  logic [3:0]  t_mem_req = '0;
  logic [31:0] t_addr = '0;
  logic [31:0] t_data = '0;
  logic [7:0]  t_lsu = '0;
  logic [31:0] t_result = '0;

  logic                 out_valid;
  logic [35:0]          word0, word1, word2, word3;
  logic [TS_BITS-1:0]   out_ts;
  logic [LVL_W-1:0]     fifo_level;
  logic [DROP_BITS-1:0] drop_count;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [TS_BITS-1:0] m_ts;
  logic               m_primed;
  logic [143:0]       m_last;
  logic [SNAP_W-1:0]  m_q[$];
  int                 m_drop;

  trace_snapshot_packer #(
    .DEPTH     (DEPTH),
    .TS_BITS   (TS_BITS),
    .DROP_BITS (DROP_BITS)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .mode       (mode),
    .clear      (clear),
    .t_active   (t_active),
    .t_pc       (t_pc),
    .t_mem_req  (t_mem_req),
    .t_addr     (t_addr),
    .t_data     (t_data),
    .t_lsu      (t_lsu),
    .t_result   (t_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .word0      (word0),
    .word1      (word1),
    .word2      (word2),
    .word3      (word3),
    .out_ts     (out_ts),
    .fifo_level (fifo_level),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [SNAP_W-1:0] got,
                           input logic [SNAP_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Trace word built by weighting each field at its bit position.
  function automatic logic [35:0] model_word(input int i);
    logic [35:0] v;
    v = 36'(t_active[i])
      + 36'(t_pc[8*i +: 8])     * 36'h2
      + 36'(t_mem_req[i])       * 36'h200
      + 36'(t_addr[8*i +: 8])   * 36'h400
      + 36'(t_data[8*i +: 8])   * 36'h40000
      + 36'(t_lsu[2*i +: 2])    * 36'h4000000
      + 36'(t_result[8*i +: 8]) * 36'h10000000;
    return v;
  endfunction

  task automatic model_reset();
    m_ts     = '0;
    m_primed = 1'b0;
    m_last   = '0;
    m_drop   = 0;
    m_q.delete();
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [143:0] snap;
    bit pop, attempt, was_full;
    snap     = {model_word(3), model_word(2), model_word(1), model_word(0)};
    pop      = (m_q.size() != 0) && out_ready;
    was_full = (m_q.size() == DEPTH);
    attempt  = enable && !clear && (!mode || !m_primed || (snap != m_last));
    if (clear) begin
      m_q.delete();
      m_drop = 0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (attempt) begin
        if (!was_full || pop) m_q.push_back({snap, m_ts});
        else if (m_drop < DROP_MAX) m_drop++;
      end
    end
    if (!enable || clear) m_primed = 1'b0;
    else if (attempt) m_primed = 1'b1;
    if (attempt) m_last = snap;
    m_ts = m_ts + 1'b1;
  endtask

  task automatic check_outputs();
    logic [SNAP_W-1:0] head;
    check_val("valid", SNAP_W'(out_valid), SNAP_W'(m_q.size() != 0));
    check_val("level", SNAP_W'(fifo_level), SNAP_W'(m_q.size()));
    check_val("drop", SNAP_W'(drop_count), SNAP_W'(m_drop));
    if (m_q.size() != 0) begin
      head = m_q[0];
      check_val("word3", SNAP_W'(word3), SNAP_W'(head[TS_BITS+108 +: 36]));
      check_val("word2", SNAP_W'(word2), SNAP_W'(head[TS_BITS+72 +: 36]));
      check_val("word1", SNAP_W'(word1), SNAP_W'(head[TS_BITS+36 +: 36]));
      check_val("word0", SNAP_W'(word0), SNAP_W'(head[TS_BITS +: 36]));
      check_val("ts", SNAP_W'(out_ts), SNAP_W'(head[TS_BITS-1:0]));
    end
  endtask

  // Called at a negedge with inputs applied; returns at the following negedge.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic zero_inputs();
    t_active = '0; t_pc = '0; t_mem_req = '0; t_addr = '0;
    t_data = '0; t_lsu = '0; t_result = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic tweak_inputs();
    int th;
    th = $urandom_range(0, 3);
    case ($urandom_range(0, 6))
      0: t_active[th]          = ~t_active[th];
      1: t_pc[8*th +: 8]       = 8'($urandom);
      2: t_mem_req[th]         = ~t_mem_req[th];
      3: t_addr[8*th +: 8]     = 8'($urandom);
      4: t_data[8*th +: 8]     = 8'($urandom);
      5: t_lsu[2*th +: 2]      = 2'($urandom);
      default: t_result[8*th +: 8] = 8'($urandom);
    endcase
  endtask

  task automatic check_reset_state();
    check_val("rst_valid", SNAP_W'(out_valid), '0);
    check_val("rst_level", SNAP_W'(fifo_level), '0);
    check_val("rst_drop", SNAP_W'(drop_count), '0);
    check_val("rst_words", SNAP_W'({word3, word2, word1, word0}), '0);
    check_val("rst_ts", SNAP_W'(out_ts), '0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_state();
    reset_n = 1'b1;
    model_reset();

    // Continuous capture of a fixed pattern with the consumer stalled.
    mode = 1'b0; enable = 1'b1; out_ready = 1'b0;
    t_pc[7:0] = 8'h12;
    repeat (3) tick();
    check_val("p1_level", SNAP_W'(fifo_level), SNAP_W'(3));
    check_val("p1_word0", SNAP_W'(word0), SNAP_W'(36'h000000024));
    check_val("p1_ts", SNAP_W'(out_ts), SNAP_W'(0));

    // Change-only capture: one snapshot for the steady pattern, one for the edit.
    do_clear();
    mode = 1'b1; enable = 1'b1;
    repeat (10) tick();
    t_addr[23:16] = 8'hA5;
    tick();
    check_val("p2_level", SNAP_W'(fifo_level), SNAP_W'(2));
    enable = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val("p2_addr", SNAP_W'(word2[17:10]), SNAP_W'(8'hA5));

    // Overflow, push-through-pop on a full FIFO, then drop counter saturation.
    do_clear();
    mode = 1'b0; enable = 1'b1;
    repeat (7) begin
      tweak_inputs();
      tick();
    end
    check_val("p3_level", SNAP_W'(fifo_level), SNAP_W'(DEPTH));
    check_val("p3_drop", SNAP_W'(drop_count), SNAP_W'(3));
    out_ready = 1'b1;
    tweak_inputs();
    tick();
    check_val("p4_level", SNAP_W'(fifo_level), SNAP_W'(DEPTH));
    check_val("p4_drop", SNAP_W'(drop_count), SNAP_W'(3));
    out_ready = 1'b0;
    repeat (251) tick();
    check_val("p5_drop254", SNAP_W'(drop_count), SNAP_W'(254));
    repeat (3) tick();
    check_val("p5_drop255", SNAP_W'(drop_count), SNAP_W'(255));
    enable = 1'b0;
    do_clear();
    check_val("p5_clr_drop", SNAP_W'(drop_count), '0);
    check_val("p5_clr_level", SNAP_W'(fifo_level), '0);
    check_val("p5_clr_valid", SNAP_W'(out_valid), '0);

    // Asynchronous reset with two buffered snapshots.
    enable = 1'b1;
    repeat (2) begin
      tweak_inputs();
      tick();
    end
    enable = 1'b0;
    check_val("p6_level", SNAP_W'(fifo_level), SNAP_W'(2));
    #2 reset_n = 1'b0;
    #1 check_reset_state();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    mode = 1'b1; enable = 1'b1;
    tick();
    check_val("p6_primed", SNAP_W'(fifo_level), SNAP_W'(1));

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      enable    = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clear     = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      if ($urandom_range(0, 2) == 0) tweak_inputs();
      if ($urandom_range(0, 9) == 0) out_ready = 1'b0;
      tick();
    end
    clear = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/trace_snapshot_packer.md
Name: trace_snapshot_packer

Overview:
- Upstream feeder of the 4-thread visualization field splitter.
- Samples per-thread core debug signals and packs each thread into a 36-bit trace word.
- Buffers 4-word snapshots in a small FIFO with a timestamp.
- Presents the head snapshot as in0..in3-compatible words over a valid/ready handshake.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, ≥2)
- TS_BITS, 16, timestamp counter width
- DROP_BITS, 8, saturating drop counter width

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  capture enable
- mode  in  1  0 = capture every enabled cycle; 1 = capture on change only
- clear  in  1  synchronous flush of FIFO, drop counter and primed flag
- t_active  in  4  thread active, bit i = thread i
- t_pc  in  32  8-bit PC per thread, thread i at [8i+7:8i]
- t_mem_req  in  4  memory request per thread
- t_addr  in  32  8-bit address per thread
- t_data  in  32  8-bit data per thread
- t_lsu  in  8  2-bit LSU state per thread, [2i+1:2i]
- t_result  in  32  8-bit ALU result per thread
- out_valid  out  1  head snapshot valid
- out_ready  in  1  consumer accepts head
- word0..word3  out  36 each  packed trace word, thread 0..3
- out_ts  out  TS_BITS  timestamp of head snapshot
- fifo_level  out  clog2(DEPTH)+1  occupancy
- drop_count  out  DROP_BITS  snapshots lost to overflow, saturating

Behaviour:
- Packing for thread i, low→high bits:
  - [0] active
  - [8:1] pc
  - [9] mem_req
  - [17:10] addr
  - [25:18] data
  - [27:26] lsu
  - [35:28] result
- snapshot = {word3, word2, word1, word0, ts}, 144 + TS_BITS bits.
- ts_ctr: free-running from reset, +1 every cycle, wraps 2^TS_BITS-1 → 0. A snapshot carries ts_ctr of its sample cycle.
- primed flag:
  - cleared by reset, by clear, and on any cycle with enable = 0;
  - set on the first capture attempt.
- last register: holds the most recent attempted 144-bit packed value; updated on every capture attempt.
- Capture attempt in cycle N when enable = 1, clear = 0, and any of:
  - mode = 0;
  - primed = 0;
  - packed ≠ last.
- Push accepted when !full, or when full and a pop occurs the same cycle.
  - Otherwise the snapshot is dropped and drop_count += 1, saturating at 2^DROP_BITS-1.
- Pop when out_valid && out_ready.
- FIFO is show-ahead:
  - out_valid = !empty;
  - word*/out_ts = head entry, driven from registers.
- Latency: sample at edge N → visible at out_valid/word* after edge N (cycle N+1), provided the FIFO was empty.
- Simultaneous push and pop:
  - level unchanged;
  - when empty, push only (no pop possible).
- Handshake: head and out_valid stay stable while out_valid && !out_ready.
- clear:
  - empties the FIFO;
  - zeros drop_count;
  - clears primed;
  - no capture that cycle;
  - ts_ctr not affected.
- enable = 0: no captures; the FIFO keeps draining.
- Reset, asynchronous:
  - out_valid = 0, fifo_level = 0, drop_count = 0;
  - word0..3 = 0, out_ts = 0;
  - ts_ctr = 0, primed = 0, last = 0, pointers = 0.
- Reset mid-transfer discards all buffered snapshots.

Decomposition:
- Package trace_pkg:
  - TRACE_W = 36, THREADS = 4;
  - field LSB/width constants (ACT, PC, MREQ, ADDR, DATA, LSU, RES);
  - typedef trace_word_t, logic [35:0];
  - typedef snapshot_t, struct of 4 trace words + ts.
- One sub-module: trace_fifo, a parameterized show-ahead sync FIFO. It provides push/pop/full/empty/level and takes the same clk/reset_n.
- Packing, change detect, counters and drop logic live in the top module.

Test Plan:
1. Reset, then mode = 0, enable = 1 for 3 cycles, out_ready = 0, thread0 pc = 8'h12, others 0 → 3 pushes, fifo_level = 3, word0 = 36'h000000024, out_ts = first sample cycle.
2. mode = 1, inputs held constant for 10 cycles, then thread2 addr = 8'hA5 → exactly 2 snapshots. The second has word2[17:10] = 8'hA5.
3. DEPTH = 4, out_ready = 0, mode = 0, 7 enabled cycles → fifo_level = 4, drop_count = 3. Head is the first sample, unchanged throughout.
4. Full FIFO, out_ready = 1 with capture in the same cycle → push accepted, level stays 4, drop_count unchanged.
5. Drop_count saturation:
   - Preload drop_count to 254 via 254 overflow drops.
   - 3 more drops → drop_count = 255.
   - clear → drop_count = 0, level = 0, out_valid = 0.
6. Assert reset_n = 0 asynchronously mid-cycle with level = 2 → out_valid and level go to 0 immediately, word0..3 = 0. After release, mode = 1 captures on the first enabled cycle because primed = 0.
